// File: rtl/lcd_ddram_reader_pkg.sv
// Shared constants and FSM state type for the HD44780 DDRAM read-back path.
// The 9-bit slot packing matches the text writer, so a written frame reads back bit-identical.
package lcd_ddram_reader_pkg;

  localparam logic [7:0] SET_DDRAM  = 8'h80;
  localparam logic [7:0] LINE0_BASE = 8'h00;
  localparam logic [7:0] LINE1_BASE = 8'h40;

  localparam int SLOT_W   = 9;
  localparam int SLOT_N   = 80;
  localparam int LINE_LEN = 40;
  localparam int FRAME_W  = SLOT_W * SLOT_N;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_ADDR,
    ST_POLL_BF,
    ST_READ_CHAR,
    ST_NEXT,
    ST_FINISH
  } rd_state_e;

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 bus cycle: T_SU setup, T_EN enable-high, T_HOLD hold, then a one-cycle done pulse.
// Handshake: start is honoured only when no cycle is active; done pulses once per cycle, rdata is valid while done is high.
module lcd_bus_cycle #(
  parameter int T_SU   = 2,
  parameter int T_EN   = 16,
  parameter int T_HOLD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe
);

  localparam int TOTAL = T_SU + T_EN + T_HOLD;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] EN_FIRST = CW'(T_SU);
  localparam logic [CW-1:0] EN_LAST  = CW'(T_SU + T_EN - 1);
  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);

  logic          active;
  logic [CW-1:0] cnt;

  // RS/RW/data are latched at start so they stay stable for the whole cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      active       <= 1'b0;
      cnt          <= '0;
      done         <= 1'b0;
      rdata        <= '0;
      lcd_rs       <= 1'b0;
      lcd_rw       <= 1'b0;
      lcd_data_out <= '0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active       <= 1'b1;
          cnt          <= '0;
          lcd_rs       <= rs;
          lcd_rw       <= rw;
          lcd_data_out <= rw ? 8'h00 : wdata;
        end
      end else begin
        if (cnt == EN_LAST) rdata <= lcd_data_in;
        if (cnt == LAST) begin
          active <= 1'b0;
          done   <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign lcd_en      = active && (cnt >= EN_FIRST) && (cnt <= EN_LAST);
  assign lcd_data_oe = active && !lcd_rw;

endmodule

// File: rtl/lcd_ddram_reader.sv
// Reads the full 80-character DDRAM image of an HD44780 into a 720-bit frame,
// polling the busy flag before every character and aborting on a poll timeout.
module lcd_ddram_reader
  import lcd_ddram_reader_pkg::*;
#(
  parameter int T_SU       = 2,
  parameter int T_EN       = 16,
  parameter int T_HOLD     = 2,
  parameter int BF_TIMEOUT = 65535
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSTART,
  output logic               oBUSY,
  output logic               oDONE,
  output logic               oERR,
  output logic [FRAME_W-1:0] oFRAME,
  input  logic [7:0]         LCD_DATA_IN,
  output logic [7:0]         LCD_DATA_OUT,
  output logic               LCD_DATA_OE,
  output logic               LCD_RW,
  output logic               LCD_RS,
  output logic               LCD_EN,
  output rd_state_e          dbg_state
);

  localparam logic [16:0] POLL_LIMIT = 17'(BF_TIMEOUT);

  rd_state_e   state, state_next;
  logic [6:0]  k;
  logic [6:0]  k_inc;
  logic [7:0]  addr;
  logic [16:0] poll_cnt;
  logic        poll_last;
  logic        bus_pend;
  logic        bus_req;
  logic        bus_start;
  logic        bus_rs;
  logic        bus_rw;
  logic [7:0]  bus_wdata;
  logic        bus_done;
  logic [7:0]  bus_rdata;

  assign k_inc     = k + 7'd1;
  assign poll_last = (poll_cnt + 17'd1) >= POLL_LIMIT;

  lcd_bus_cycle #(
    .T_SU  (T_SU),
    .T_EN  (T_EN),
    .T_HOLD(T_HOLD)
  ) u_bus (
    .clk         (iCLK),
    .rst         (iRST),
    .start       (bus_start),
    .rs          (bus_rs),
    .rw          (bus_rw),
    .wdata       (bus_wdata),
    .done        (bus_done),
    .rdata       (bus_rdata),
    .lcd_data_in (LCD_DATA_IN),
    .lcd_en      (LCD_EN),
    .lcd_rs      (LCD_RS),
    .lcd_rw      (LCD_RW),
    .lcd_data_out(LCD_DATA_OUT),
    .lcd_data_oe (LCD_DATA_OE)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:      if (iSTART) state_next = ST_SET_ADDR;
      ST_SET_ADDR:  if (bus_done) state_next = ST_POLL_BF;
      ST_POLL_BF: begin
        if (bus_done) begin
          if (!bus_rdata[7])  state_next = ST_READ_CHAR;
          else if (poll_last) state_next = ST_FINISH;
        end
      end
      ST_READ_CHAR: if (bus_done) state_next = ST_NEXT;
      ST_NEXT: begin
        if (k_inc == 7'(LINE_LEN))    state_next = ST_SET_ADDR;
        else if (k_inc == 7'(SLOT_N)) state_next = ST_FINISH;
        else                          state_next = ST_POLL_BF;
      end
      ST_FINISH:    state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Each bus-using state launches exactly one bus cycle per visit; a repeated
  // POLL_BF visit relaunches because bus_pend drops with done.
  always_comb begin
    bus_req   = 1'b0;
    bus_rs    = 1'b0;
    bus_rw    = 1'b0;
    bus_wdata = 8'h00;
    case (state)
      ST_SET_ADDR: begin
        bus_req   = 1'b1;
        bus_wdata = SET_DDRAM | addr;
      end
      ST_POLL_BF: begin
        bus_req = 1'b1;
        bus_rw  = 1'b1;
      end
      ST_READ_CHAR: begin
        bus_req = 1'b1;
        bus_rs  = 1'b1;
        bus_rw  = 1'b1;
      end
      default: ;
    endcase
    bus_start = bus_req && !bus_pend;
    oBUSY     = (state != ST_IDLE) && (state != ST_FINISH);
    oDONE     = (state == ST_FINISH);
    dbg_state = state;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      k        <= '0;
      addr     <= LINE0_BASE;
      poll_cnt <= '0;
      bus_pend <= 1'b0;
      oERR     <= 1'b0;
      oFRAME   <= '0;
    end else begin
      if (bus_start)     bus_pend <= 1'b1;
      else if (bus_done) bus_pend <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iSTART) begin
            oERR <= 1'b0;
            k    <= '0;
            addr <= LINE0_BASE;
          end
        end
        ST_POLL_BF: begin
          if (bus_done) begin
            poll_cnt <= poll_cnt + 17'd1;
            if (bus_rdata[7] && poll_last) oERR <= 1'b1;
          end
        end
        ST_READ_CHAR: begin
          if (bus_done) oFRAME[k*SLOT_W +: SLOT_W] <= {1'b1, bus_rdata};
        end
        ST_NEXT: begin
          k <= k_inc;
          if (k_inc == 7'(LINE_LEN)) addr <= LINE1_BASE;
        end
        default: ;
      endcase
      if (state_next == ST_POLL_BF && state != ST_POLL_BF) poll_cnt <= '0;
    end
  end

endmodule
